clk_div_monitor: RTL and testbench
==================================

Name: clk_div_monitor

Overview:
- Downstream checker for a divided-clock signal generated in the `clk` domain.
- Detects rising and falling edges of the divided signal and emits single-cycle ticks that downstream logic uses as clock enables.
- Measures period and high time in `clk` cycles, declares lock after repeated correct periods, and flags loss of lock or a stalled divider.

Parameters:
- PERIOD, 4, expected divided-clock period in `clk` cycles (≥2).
- TOL, 0, allowed absolute deviation of measured period from PERIOD, in cycles.
- LOCK_CNT, 4, consecutive in-tolerance periods required to assert lock (≥1).
- CW, $clog2(2*PERIOD+2), width of the measurement counters and outputs (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clk_div_in  input  1  divided-clock signal, synchronous to `clk`.
- err_clr  input  1  single-cycle clear of the sticky error flag.
- rise_tick  output  1  one-cycle pulse per rising edge of `clk_div_in`.
- fall_tick  output  1  one-cycle pulse per falling edge of `clk_div_in`.
- period  output  CW  last measured period, in cycles.
- high_time  output  CW  last measured high time, in cycles.
- meas_valid  output  1  one-cycle pulse when `period` updates.
- locked  output  1  lock indicator.
- timeout  output  1  one-cycle pulse when no rising edge arrives within the limit.
- err  output  1  sticky error flag.

Behaviour:
- Reset (async, `rst_n`=0):
  - Internal regs are cleared: `s0`, `s1`, `per_cnt`, `hi_cnt`, `match_cnt`, `first`=1.
  - All outputs are 0, including `period` and `high_time`.
- Edge detect:
  - `s0` <= `clk_div_in`; `s1` <= `s0`.
  - `rise` = `s0` & ~`s1`; `fall` = ~`s0` & `s1`.
  - `rise_tick`/`fall_tick` are registered copies of `rise`/`fall`.
  - Tick latency: the tick is high in the 2nd cycle after the first `clk` edge that samples the new level.
- Period counter `per_cnt`:
  - +1 every cycle, saturating at 2*PERIOD.
  - On `rise`: `per_cnt` <= 0.
  - On `rise` with `first`=0: `period` <= `per_cnt`+1 and `meas_valid` pulses in the same cycle as `rise_tick`.
  - On `rise` with `first`=1: no measurement; `first` <= 0.
- High counter `hi_cnt`:
  - Cleared on `rise`; +1 per cycle, saturating at 2*PERIOD.
  - On `fall` with `first`=0: `high_time` <= `hi_cnt`+1.
  - A fall before any rise after reset is ignored for measurement.
- Lock:
  - On each measured period, match = |`period_new` − PERIOD| ≤ TOL.
  - Match: `match_cnt` increments, saturating at LOCK_CNT; `locked` = (`match_cnt`==LOCK_CNT), registered.
  - Mismatch: `match_cnt` <= 0 and `locked` <= 0.
  - A mismatch while `locked`=1 sets `err`.
- Timeout:
  - When `per_cnt` reaches 2*PERIOD with no `rise`, `timeout` pulses exactly once.
  - Consequences: `locked` <= 0, `match_cnt` <= 0, `first` <= 1, so the next rise restarts measurement.
  - `err` is set if `locked` was 1.
  - No further timeout pulses occur until a rise re-arms it.
- err:
  - Sticky; cleared by `err_clr`.
  - If a set event and `err_clr` occur in the same cycle, set wins.
- Simultaneous events:
  - `rise` and timeout saturation in the same cycle: rise wins and no timeout is reported.
  - `rise` and `fall` cannot coincide.
- Reset mid-operation: everything clears immediately (async); lock must be re-acquired from scratch.
- Constant-high or constant-low input after lock: treated as timeout.

Test Plan:
All scenarios use PERIOD=4, TOL=0, LOCK_CNT=4.
1. Release reset; drive a 50%-duty period-4 square wave (2 high, 2 low) → first rise gives no `meas_valid`; then `period`=4 and `high_time`=2 on every edge; `locked`=1 after the 4th `meas_valid`; `err`=0.
2. Lock, then stretch one period to 5 cycles → that measurement gives `period`=5; `locked` falls to 0 and `err` rises in the same cycle; 4 further good periods re-lock; `err` stays 1 until `err_clr` pulses.
3. Lock, then hold `clk_div_in` high → exactly one `timeout` pulse 8 cycles after the last rise; `locked`=0; `err`=1; the next rise produces no `meas_valid`.
4. Assert `err_clr` in the same cycle as a lock-loss mismatch → `err` ends at 1; `err_clr` alone on a later cycle → `err`=0.
5. Assert `rst_n`=0 mid-high-phase while locked → all outputs 0 immediately, without waiting for `clk`; after release, behaviour matches scenario 1.
6. Drive a 25%-duty period-4 wave (1 high, 3 low) → `high_time`=1, `period`=4, and lock is acquired normally.

Source files
------------

// File: rtl/clk_div_monitor.sv
// Checker for a divided clock in the clk domain: edge ticks, period and high-time
// measurement, lock tracking, stall timeout and a sticky error flag.
module clk_div_monitor #(
  parameter int PERIOD   = 4,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int CW       = $clog2(2*PERIOD+2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_div_in,
  input  logic          err_clr,
  output logic          rise_tick,
  output logic          fall_tick,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          meas_valid,
  output logic          locked,
  output logic          timeout,
  output logic          err
);

  localparam int          LW      = $clog2(LOCK_CNT+1);
  localparam logic [CW-1:0] SAT_C  = CW'(2*PERIOD);
  localparam logic [CW-1:0] SAT_M1 = CW'(2*PERIOD-1);
  localparam logic [LW-1:0] LOCK_C = LW'(LOCK_CNT);
  localparam int unsigned LO_LIM  = (PERIOD > TOL) ? PERIOD - TOL : 0;
  localparam int unsigned HI_LIM  = PERIOD + TOL;

  logic          s0_q, s1_q;
  logic [CW-1:0] per_cnt_q, per_cnt_d;
  logic [CW-1:0] hi_cnt_q, hi_cnt_d;
  logic [LW-1:0] match_q, match_d;
  logic          first_q, first_d;
  logic          rise_tick_q, fall_tick_q;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_time_q, high_time_d;
  logic          meas_valid_q, meas_valid_d;
  logic          locked_q, locked_d;
  logic          timeout_q, timeout_d;
  logic          err_q, err_d;

  logic          rise, fall;
  logic          err_set;
  logic          in_tol;
  logic [CW-1:0] period_new;
  logic [31:0]   period_new32;

  assign rise         = s0_q & ~s1_q;
  assign fall         = ~s0_q & s1_q;
  assign period_new   = per_cnt_q + CW'(1);
  assign period_new32 = 32'(period_new);
  assign in_tol       = (period_new32 >= LO_LIM) && (period_new32 <= HI_LIM);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    per_cnt_d    = (per_cnt_q == SAT_C) ? per_cnt_q : per_cnt_q + CW'(1);
    hi_cnt_d     = (hi_cnt_q == SAT_C) ? hi_cnt_q : hi_cnt_q + CW'(1);
    match_d      = match_q;
    first_d      = first_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    timeout_d    = 1'b0;
    err_set      = 1'b0;

    if (rise) begin
      per_cnt_d = '0;
      hi_cnt_d  = '0;
      if (first_q) begin
        first_d = 1'b0;
      end else begin
        period_d     = period_new;
        meas_valid_d = 1'b1;
        if (in_tol) begin
          if (match_q != LOCK_C) match_d = match_q + LW'(1);
          locked_d = (match_d == LOCK_C);
        end else begin
          match_d  = '0;
          locked_d = 1'b0;
          err_set  = locked_q;
        end
      end
    end else if (per_cnt_q == SAT_M1) begin
      // Counter saturates after this edge and stays there until the next rise,
      // so this branch fires once per stall.
      timeout_d = 1'b1;
      match_d   = '0;
      locked_d  = 1'b0;
      first_d   = 1'b1;
      err_set   = locked_q;
    end

    if (fall && !first_q) high_time_d = hi_cnt_q + CW'(1);

    err_d = err_set | (err_q & ~err_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q         <= 1'b0;
      s1_q         <= 1'b0;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      match_q      <= '0;
      first_q      <= 1'b1;
      rise_tick_q  <= 1'b0;
      fall_tick_q  <= 1'b0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      s0_q         <= clk_div_in;
      s1_q         <= s0_q;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      match_q      <= match_d;
      first_q      <= first_d;
      rise_tick_q  <= rise;
      fall_tick_q  <= fall;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
      err_q        <= err_d;
    end
  end

  assign rise_tick  = rise_tick_q;
  assign fall_tick  = fall_tick_q;
  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;
  assign err        = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: segment table plus hand sequences, with an event
// scoreboard predicting every tick/measurement cycle from the driven waveform.
module tb_clk_div_monitor;

  localparam int PERIOD   = 4;
  localparam int TOL      = 0;
  localparam int LOCK_CNT = 4;
  localparam int CW       = $clog2(2*PERIOD+2);
  localparam int SAT      = 2*PERIOD;

  logic          clk, rst_n, clk_div_in, err_clr;
  logic          rise_tick, fall_tick, meas_valid, locked, timeout, err;
  logic [CW-1:0] period, high_time;

  clk_div_monitor #(.PERIOD(PERIOD), .TOL(TOL), .LOCK_CNT(LOCK_CNT)) dut (
    .clk(clk), .rst_n(rst_n), .clk_div_in(clk_div_in), .err_clr(err_clr),
    .rise_tick(rise_tick), .fall_tick(fall_tick), .period(period),
    .high_time(high_time), .meas_valid(meas_valid), .locked(locked),
    .timeout(timeout), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected DUT state at the cycle an event becomes visible.
  typedef struct {
    int            cyc;
    logic [3:0]    ticks;   // {rise, fall, meas_valid, timeout}
    logic [CW-1:0] per;
    logic [CW-1:0] ht;
    logic          lk;
    logic          er;
  } ev_t;

  ev_t evq[$];
  logic mon_en = 1'b0;

  // Behavioural model of the checker, in terms of driven levels and due cycles.
  logic          m_prev, m_first, m_locked, m_err, m_armed;
  int            m_match, m_rise_due, m_set_due;
  logic [CW-1:0] m_per, m_ht;

  task automatic reset_model();
    m_prev = 1'b0; m_first = 1'b1; m_locked = 1'b0; m_err = 1'b0; m_armed = 1'b1;
    m_match = 0; m_rise_due = cyc; m_set_due = -100; m_per = '0; m_ht = '0;
  endtask

  task automatic step(input logic lvl, input logic clr);
    ev_t  e;
    logic rise_n, fall_n, to_n, mv;
    int   due, p, dev;
    @(posedge clk);
    #1;
    clk_div_in = lvl;
    err_clr    = clr;
    due = cyc + 2;
    if (clr && m_set_due != cyc + 1) begin
      m_err = 1'b0;
      if (evq.size() > 0 && evq[evq.size()-1].cyc == cyc + 1) evq[evq.size()-1].er = 1'b0;
    end
    rise_n = lvl & ~m_prev;
    fall_n = ~lvl & m_prev;
    m_prev = lvl;
    to_n   = m_armed && !rise_n && (due == m_rise_due + SAT);
    mv     = 1'b0;
    if (fall_n && !m_first) begin
      p = due - m_rise_due;
      if (p > SAT + 1) p = SAT + 1;
      m_ht = CW'(p);
    end
    if (rise_n) begin
      if (m_first) m_first = 1'b0;
      else begin
        mv = 1'b1;
        p = due - m_rise_due;
        if (p > SAT + 1) p = SAT + 1;
        m_per = CW'(p);
        dev = (p > PERIOD) ? p - PERIOD : PERIOD - p;
        if (dev <= TOL) begin
          if (m_match < LOCK_CNT) m_match++;
          m_locked = (m_match == LOCK_CNT);
        end else begin
          if (m_locked) begin m_err = 1'b1; m_set_due = due; end
          m_match = 0; m_locked = 1'b0;
        end
      end
      m_rise_due = due;
      m_armed = 1'b1;
    end
    if (to_n) begin
      if (m_locked) begin m_err = 1'b1; m_set_due = due; end
      m_armed = 1'b0; m_locked = 1'b0; m_match = 0; m_first = 1'b1;
    end
    if (rise_n || fall_n || to_n) begin
      e.cyc = due; e.ticks = {rise_n, fall_n, mv, to_n};
      e.per = m_per; e.ht = m_ht; e.lk = m_locked; e.er = m_err;
      evq.push_back(e);
    end
  endtask

  ev_t mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        mon_e = evq.pop_front();
        check("ev_ticks", 32'({rise_tick, fall_tick, meas_valid, timeout}), 32'(mon_e.ticks));
        check("ev_period", 32'(period), 32'(mon_e.per));
        check("ev_high_time", 32'(high_time), 32'(mon_e.ht));
        check("ev_locked", 32'(locked), 32'(mon_e.lk));
        check("ev_err", 32'(err), 32'(mon_e.er));
      end else begin
        check("idle_ticks", 32'({rise_tick, fall_tick, meas_valid, timeout}), 32'(0));
      end
    end
  end

  task automatic apply_reset();
    mon_en = 1'b0;
    rst_n = 1'b0; clk_div_in = 1'b0; err_clr = 1'b0;
    evq.delete();
    #1;
    check("rst_ticks_err", 32'({rise_tick, fall_tick, meas_valid, timeout, err}), 32'(0));
    check("rst_locked", 32'(locked), 32'(0));
    check("rst_period", 32'(period), 32'(0));
    check("rst_high_time", 32'(high_time), 32'(0));
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    reset_model();
    mon_en = 1'b1;
  endtask

  typedef enum logic [1:0] {P_NONE, P_CLR, P_S4, P_S5} post_e;
  typedef struct {
    int            hi;
    int            lo;
    int            reps;
    logic          exp_locked;
    logic          exp_err;
    logic [CW-1:0] exp_per;
    logic [CW-1:0] exp_ht;
    post_e         post;
  } seg_t;

  seg_t segs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    segs[0] = '{2,  2, 5, 1'b1, 1'b0, 4'd4, 4'd2, P_NONE}; // lock on 50% wave
    segs[1] = '{2,  3, 1, 1'b1, 1'b0, 4'd4, 4'd2, P_NONE}; // stretched period
    segs[2] = '{2,  2, 5, 1'b1, 1'b1, 4'd4, 4'd2, P_CLR};  // unlock, err, relock
    segs[3] = '{12, 2, 1, 1'b0, 1'b1, 4'd4, 4'd2, P_NONE}; // stall high -> timeout
    segs[4] = '{2,  2, 5, 1'b1, 1'b1, 4'd4, 4'd2, P_S4};   // restart after timeout
    segs[5] = '{2,  2, 5, 1'b1, 1'b0, 4'd4, 4'd2, P_S5};   // relock, then reset
    segs[6] = '{1,  3, 5, 1'b1, 1'b0, 4'd4, 4'd1, P_NONE}; // 25% duty after reset

    rst_n = 1'b1; clk_div_in = 1'b0; err_clr = 1'b0;
    #2;
    apply_reset();

    for (int s = 0; s < 7; s++) begin
      for (int r = 0; r < segs[s].reps; r++) begin
        for (int k = 0; k < segs[s].hi; k++) step(1'b1, 1'b0);
        for (int k = 0; k < segs[s].lo; k++) step(1'b0, 1'b0);
      end
      check($sformatf("seg%0d_locked", s), 32'(locked), 32'(segs[s].exp_locked));
      check($sformatf("seg%0d_err", s), 32'(err), 32'(segs[s].exp_err));
      check($sformatf("seg%0d_period", s), 32'(period), 32'(segs[s].exp_per));
      check($sformatf("seg%0d_high_time", s), 32'(high_time), 32'(segs[s].exp_ht));
      case (segs[s].post)
        P_CLR: begin
          // err_clr on a quiet edge inside a normal period
          step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
          check("clr_alone_err", 32'(err), 32'(0));
          check("clr_alone_locked", 32'(locked), 32'(1));
        end
        P_S4: begin
          step(1'b0, 1'b1); step(1'b0, 1'b0);
          check("s4_pre_clear_err", 32'(err), 32'(0));
          // 6-cycle period breaks lock; err_clr lands on the same edge
          step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b0);
          check("s4_set_wins_err", 32'(err), 32'(1));
          check("s4_set_wins_locked", 32'(locked), 32'(0));
          step(1'b0, 1'b1); step(1'b0, 1'b0);
          check("s4_later_clear_err", 32'(err), 32'(0));
        end
        P_S5: begin
          step(1'b1, 1'b0); step(1'b1, 1'b0);
          check("s5_locked_before_reset", 32'(locked), 32'(1));
          #2;
          apply_reset();
        end
        default: ;
      endcase
    end

    // Constant low after lock: one timeout, lock lost, err raised.
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 32'(evq.size()), 32'(0));
    check("final_locked", 32'(locked), 32'(0));
    check("final_err", 32'(err), 32'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
